// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aud_pkg
// Description : Types and constants shared by the audio record and playback
//               paths: the controller state encoding plus the default sample
//               width and SRAM word-address width.
// Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

  localparam int AUD_ADDR_W = 20;
  localparam int AUD_WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIFT = 3'd2,
    ADV   = 3'd3,
    PAUSE = 3'd4
  } aud_state_t;

endpackage
`default_nettype wire

// File: rtl/aud_i2s_deser.sv
`default_nettype none
// ============================================================================
// Module      : aud_i2s_deser
// Description : Left-channel I2S deserializer. It detects the LRC falling edge
//               (E0, the one-bit delay slot), then shifts in WORD_W bits MSB
//               first on E1..E16.
// Ports       : i_clk   - bit clock
//               i_rst   - synchronous active-high reset
//               i_lrc   - ADCLRCK (low = left)
//               i_data  - ADCDAT serial bit
//               i_en    - capture allowed (controller waiting or shifting)
//               o_word  - assembled word, valid together with o_valid
//               o_valid - high during the cycle whose edge samples the LSB
//               o_sof   - high during the cycle whose edge is E0
// Revision    : 1.0 - initial release
// ============================================================================
module aud_i2s_deser #(
  parameter int WORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_en,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_sof
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic              prev_lrc;
  logic              active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;

  // Only an idle (not yet capturing) enabled deserializer arms on an LRC
  // fall, so falls seen while disabled are ignored.
  assign o_sof   = i_en && !active && !i_lrc && prev_lrc;
  assign o_valid = active && (bit_cnt == LAST_BIT);
  // The bit arriving on this edge completes the word combinationally so the
  // controller can register it on the LSB edge itself.
  assign o_word  = {shreg[WORD_W-2:0], i_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_lrc <= 1'b1;
      active   <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      prev_lrc <= i_lrc;
      if (!i_en) begin
        active  <= 1'b0;
        bit_cnt <= '0;
      end else if (!active) begin
        if (o_sof) begin
          active  <= 1'b1;
          bit_cnt <= '0;
        end
      end else begin
        shreg   <= o_word;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (o_valid) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aud_rec_writer.sv
`default_nettype none
// ============================================================================
// Module      : aud_rec_writer
// Description : Records the left channel of the codec ADC I2S stream into
//               SRAM at incrementing addresses under start/pause/stop control
//               and reports the recorded length.
// Ports       : i_clk, i_rst        - bit clock, sync active-high reset
//               i_start/i_pause/i_stop - level controls (stop > start > pause)
//               i_lrc, i_data       - ADCLRCK / ADCDAT
//               o_address, o_data, o_we - SRAM write port
//               o_len               - samples written in this/last recording
//               o_full              - last address written
//               o_busy              - not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module aud_rec_writer
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter int                WORD_W   = AUD_WORD_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [WORD_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_busy
);

  aud_state_t        state;
  aud_state_t        state_next;
  logic              deser_en;
  logic              sof;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              pause_pending;
  logic              stop_pending;
  logic              at_max;

  assign deser_en = (state == WAIT) || (state == SHIFT);
  assign at_max   = (o_address == ADDR_MAX);
  assign o_busy   = (state != IDLE);

  aud_i2s_deser #(
    .WORD_W (WORD_W)
  ) u_deser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_lrc   (i_lrc),
    .i_data  (i_data),
    .i_en    (deser_en),
    .o_word  (word),
    .o_valid (word_valid),
    .o_sof   (sof)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (i_start && !i_stop) state_next = WAIT;
      WAIT: begin
        if (i_stop)       state_next = IDLE;
        else if (i_pause) state_next = PAUSE;
        else if (sof)     state_next = SHIFT;
      end
      // A stop landing on the LSB edge still lets the word be written.
      SHIFT: begin
        if (word_valid)  state_next = ADV;
        else if (i_stop) state_next = IDLE;
      end
      ADV: begin
        if (i_stop || stop_pending || at_max) state_next = IDLE;
        else if (pause_pending)               state_next = PAUSE;
        else                                  state_next = WAIT;
      end
      PAUSE: begin
        if (i_stop)       state_next = IDLE;
        else if (i_start) state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_address     <= '0;
      o_data        <= '0;
      o_we          <= 1'b0;
      o_len         <= '0;
      o_full        <= 1'b0;
      pause_pending <= 1'b0;
      stop_pending  <= 1'b0;
    end else begin
      o_we <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            o_address     <= '0;
            o_len         <= '0;
            o_full        <= 1'b0;
            pause_pending <= 1'b0;
            stop_pending  <= 1'b0;
          end
        end
        SHIFT: begin
          if (i_pause) pause_pending <= 1'b1;
          if (word_valid) begin
            o_data <= word;
            o_we   <= 1'b1;
            if (i_stop) stop_pending <= 1'b1;
          end
        end
        ADV: begin
          if (at_max) begin
            o_full <= 1'b1;
            o_len  <= {1'b0, ADDR_MAX} + (ADDR_W+1)'(1);
          end else begin
            o_address <= o_address + ADDR_W'(1);
            o_len     <= o_len + (ADDR_W+1)'(1);
          end
          stop_pending <= 1'b0;
        end
        PAUSE: begin
          if (i_start && !i_stop) pause_pending <= 1'b0;
        end
        default: ;
      endcase
      if (state != IDLE && state_next == IDLE) begin
        pause_pending <= 1'b0;
        stop_pending  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_rec_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aud_rec_writer
// Description : Scoreboard bench for aud_rec_writer. Stimulus pushes expected
//               SRAM writes into a queue; a monitor pops and compares on
//               every o_we. The DUT uses ADDR_MAX = 3 so the full condition
//               is reachable in a few frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_rec_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic        lrc = 1'b1, data = 1'b0;
  logic [19:0] address;
  logic [15:0] wdata;
  logic        we;
  logic [20:0] len;
  logic        full, busy;

  int checks = 0;
  int errors = 0;
  int edge_k = -1;
  int we_k   = -99;
  logic [35:0] exp_q[$];
  logic [35:0] exp_e;

  always #5 clk = ~clk;

  aud_rec_writer #(
    .ADDR_W   (20),
    .WORD_W   (16),
    .ADDR_MAX (20'd3)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_pause   (pause),
    .i_stop    (stop),
    .i_lrc     (lrc),
    .i_data    (data),
    .o_address (address),
    .o_data    (wdata),
    .o_we      (we),
    .o_len     (len),
    .o_full    (full),
    .o_busy    (busy)
  );

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      checks++;
      we_k = edge_k;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", address, wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({address, wdata} !== exp_e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   address, wdata, exp_e[35:16], exp_e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input logic l, input logic d, input logic s,
                      input logic p, input logic t, input logic r);
    @(negedge clk);
    lrc = l; data = d; start = s; pause = p; stop = t; rst = r;
    @(posedge clk);
    #1;
  endtask

  // One 32-bit I2S frame: edge 0 is E0 (left slot delay bit), edges 1..16
  // carry the left word MSB first, edges 17..31 the right word's top bits.
  // act: 1 = pause, 2 = stop, 3 = reset, asserted for edge act_k only.
  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int act_k, input int act);
    logic d, lv;
    for (int k = 0; k < 32; k++) begin
      lv = (k >= 16);
      if (k == 0)       d = 1'b0;
      else if (k <= 16) d = l[16-k];
      else              d = r[32-k];
      step(lv, d, 1'b0, (k == act_k) && (act == 1), (k == act_k) && (act == 2),
           (k == act_k) && (act == 3));
      edge_k = k;
    end
    edge_k = -1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    step(1'b1, 1'b0, s, p, t, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_address", address, 0);
    check("rst_data", wdata, 0);
    check("rst_we", we, 0);
    check("rst_len", len, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);

    // 1: single word
    pulse(1, 0, 0);
    check("t1_busy", busy, 1);
    exp_q.push_back({20'd0, 16'hA5C3});
    frame(16'hA5C3, 16'hFFFF, -1, 0);
    check("t1_we_edge", we_k, 16);
    check("t1_address", address, 1);
    check("t1_len", len, 1);

    // 2: three consecutive frames, right word never written
    pulse(0, 0, 1);
    check("t2_stop_busy", busy, 0);
    check("t2_stop_len", len, 1);
    pulse(1, 0, 0);
    exp_q.push_back({20'd0, 16'h0001});
    exp_q.push_back({20'd1, 16'h8000});
    exp_q.push_back({20'd2, 16'h7FFF});
    frame(16'h0001, 16'hFFFF, -1, 0);
    frame(16'h8000, 16'hFFFF, -1, 0);
    frame(16'h7FFF, 16'hFFFF, -1, 0);
    check("t2_len", len, 3);
    check("t2_full", full, 0);

    // 3: pause mid-word, resume
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    exp_q.push_back({20'd0, 16'h1111});
    exp_q.push_back({20'd1, 16'h2222});
    frame(16'h1111, 16'hFFFF, -1, 0);
    frame(16'h2222, 16'hFFFF, 8, 1);
    for (int i = 0; i < 4; i++) frame(16'h3333, 16'hFFFF, -1, 0);
    check("t3_pause_len", len, 2);
    check("t3_pause_busy", busy, 1);
    pulse(1, 0, 0);
    exp_q.push_back({20'd2, 16'h4444});
    frame(16'h4444, 16'hFFFF, -1, 0);
    check("t3_len", len, 3);

    // 4: stop mid-word, then fresh start
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    exp_q.push_back({20'd0, 16'h5555});
    exp_q.push_back({20'd1, 16'h6666});
    frame(16'h5555, 16'hFFFF, -1, 0);
    frame(16'h6666, 16'hFFFF, -1, 0);
    frame(16'h7777, 16'hFFFF, 10, 2);
    check("t4_len", len, 2);
    check("t4_address", address, 2);
    check("t4_busy", busy, 0);
    pulse(1, 0, 0);
    check("t4_restart_len", len, 0);
    check("t4_restart_address", address, 0);
    exp_q.push_back({20'd0, 16'h8888});
    frame(16'h8888, 16'hFFFF, -1, 0);
    check("t4_len2", len, 1);

    // 5: fill to ADDR_MAX = 3
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back({20'(i), 16'h9000 + 16'(i)});
    for (int i = 0; i < 5; i++) frame(16'h9000 + 16'(i), 16'hFFFF, -1, 0);
    check("t5_full", full, 1);
    check("t5_len", len, 4);
    check("t5_address", address, 3);
    check("t5_busy", busy, 0);

    // 6: reset mid-word, then start+stop together in IDLE
    pulse(1, 0, 0);
    check("t6_full_cleared", full, 0);
    frame(16'hAAAA, 16'hFFFF, 5, 3);
    check("t6_address", address, 0);
    check("t6_data", wdata, 0);
    check("t6_we", we, 0);
    check("t6_len", len, 0);
    check("t6_full", full, 0);
    check("t6_busy", busy, 0);
    pulse(1, 0, 1);
    check("t6_startstop_busy", busy, 0);
    frame(16'hBBBB, 16'hFFFF, -1, 0);
    check("t6_idle_busy", busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
